div_arbiter: RTL and testbench

- Shares one sequential divider among three requesters: instantaneous speed (0), average speed (1) and distance/odometer scaling (2).
- Replaces the fixed half-second alternation of speed and avg-speed starts with request-driven, round-robin scheduling.
- Snapshots each requester's operands and issues one divide at a time.
- Returns the quotient with a one-hot valid pulse to the owning requester, and handles divide-by-zero and divider timeout.

---
 rtl/div_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Shares one sequential divider among three requesters (speed, avg speed, distance).
// Round-robin scheduling over operand snapshots; one divide in flight at a time.
module div_arbiter #(
  parameter int DIVIDEND_WIDTH = 20,
  parameter int DIVISOR_WIDTH  = 14,
  parameter int QUOTIENT_WIDTH = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                req,
  input  logic [DIVIDEND_WIDTH-1:0] dividend0,
  input  logic [DIVIDEND_WIDTH-1:0] dividend1,
  input  logic [DIVIDEND_WIDTH-1:0] dividend2,
  input  logic [DIVISOR_WIDTH-1:0]  divisor0,
  input  logic [DIVISOR_WIDTH-1:0]  divisor1,
  input  logic [DIVISOR_WIDTH-1:0]  divisor2,
  output logic                      div_start,
  output logic [DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic                      div_valid,
  input  logic [QUOTIENT_WIDTH-1:0] div_quotient,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [2:0]                valid,
  output logic [1:0]                grant,
  output logic                      busy,
  output logic                      err_timeout
);

  // state | meaning
  // IDLE  | waiting for a pending request; arbitrates round-robin from rr
  // ISSUE | one-cycle divider start pulse
  // WAIT  | waiting for div_valid, bounded by the timeout counter
  // DONE  | one-cycle one-hot valid to the owner

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [2:0]                pending_q;
  logic [1:0]                rr_q;
  logic [CW-1:0]             cnt_q;
  logic [1:0]                grant_q;
  logic [DIVIDEND_WIDTH-1:0] dividend_q;
  logic [DIVISOR_WIDTH-1:0]  divisor_q;
  logic [QUOTIENT_WIDTH-1:0] result_q;

  logic [DIVIDEND_WIDTH-1:0] snap_dvd_q [3];
  logic [DIVISOR_WIDTH-1:0]  snap_dvs_q [3];

  logic                      pick_found;
  logic [1:0]                pick_idx;
  logic [1:0]                cand0, cand1, cand2;
  logic [DIVIDEND_WIDTH-1:0] sel_dvd;
  logic [DIVISOR_WIDTH-1:0]  sel_dvs;
  logic                      take;
  logic                      zero_div;
  logic                      timeout_hit;
  logic [2:0]                clr_mask;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Snapshots: newest operands overwrite, no queueing per requester.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        snap_dvd_q[i] <= '0;
        snap_dvs_q[i] <= '0;
      end
    end else begin
      if (req[0]) begin
        snap_dvd_q[0] <= dividend0;
        snap_dvs_q[0] <= divisor0;
      end
      if (req[1]) begin
        snap_dvd_q[1] <= dividend1;
        snap_dvs_q[1] <= divisor1;
      end
      if (req[2]) begin
        snap_dvd_q[2] <= dividend2;
        snap_dvs_q[2] <= divisor2;
      end
    end
  end

  assign cand0 = rr_q;
  assign cand1 = inc3(cand0);
  assign cand2 = inc3(cand1);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    if (pending_q[cand0]) begin
      pick_found = 1'b1;
      pick_idx   = cand0;
    end else if (pending_q[cand1]) begin
      pick_found = 1'b1;
      pick_idx   = cand1;
    end else if (pending_q[cand2]) begin
      pick_found = 1'b1;
      pick_idx   = cand2;
    end
  end

  always_comb begin
    sel_dvd = snap_dvd_q[2];
    sel_dvs = snap_dvs_q[2];
    case (pick_idx)
      2'd0: begin
        sel_dvd = snap_dvd_q[0];
        sel_dvs = snap_dvs_q[0];
      end
      2'd1: begin
        sel_dvd = snap_dvd_q[1];
        sel_dvs = snap_dvs_q[1];
      end
      default: begin
        sel_dvd = snap_dvd_q[2];
        sel_dvs = snap_dvs_q[2];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    zero_div    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          take = 1'b1;
          if (sel_dvs == '0) begin
            zero_div = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (div_valid) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A same-cycle req for the winner re-sets its pending bit after the clear.
  assign clr_mask = take ? (3'b001 << pick_idx) : 3'b000;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q & ~clr_mask) | req;
      if (take) begin
        grant_q    <= pick_idx;
        dividend_q <= sel_dvd;
        divisor_q  <= sel_dvs;
        rr_q       <= inc3(pick_idx);
      end
      if (zero_div) result_q <= '1;
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        if (div_valid) result_q <= div_quotient;
        else           cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

  assign div_start    = (state_q == S_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign quotient     = result_q;
  assign valid        = (state_q == S_DONE) ? (3'b001 << grant_q) : 3'b000;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = timeout_hit;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider and a result scoreboard.
module tb_div_arbiter;
  localparam int DW = 20;
  localparam int SW = 14;
  localparam int QW = 10;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [DW-1:0] dividend0, dividend1, dividend2;
  logic [SW-1:0] divisor0, divisor1, divisor2;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [SW-1:0] div_divisor;
  logic          div_valid;
  logic [QW-1:0] div_quotient;
  logic [QW-1:0] quotient;
  logic [2:0]    valid;
  logic [1:0]    grant;
  logic          busy;
  logic          err_timeout;

  div_arbiter #(
    .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .QUOTIENT_WIDTH(QW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .req(req),
    .dividend0(dividend0), .dividend1(dividend1), .dividend2(dividend2),
    .divisor0(divisor0), .divisor1(divisor1), .divisor2(divisor2),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid(div_valid), .div_quotient(div_quotient),
    .quotient(quotient), .valid(valid), .grant(grant), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural divider: result strobe lat cycles after the start pulse.
  int            lat = 12;
  bit            model_en = 1'b1;
  int            rem;
  logic          m_valid;
  logic [QW-1:0] m_q;
  logic          inj_valid = 1'b0;
  logic [QW-1:0] inj_q = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem     <= 0;
      m_valid <= 1'b0;
      m_q     <= '0;
    end else begin
      m_valid <= 1'b0;
      if (div_start) begin
        rem <= lat - 1;
        m_q <= (div_divisor == '0) ? '1 : QW'(div_dividend / DW'(div_divisor));
      end else if (rem > 0) begin
        if (rem == 1 && model_en) m_valid <= 1'b1;
        rem <= rem - 1;
      end
    end
  end

  assign div_valid    = m_valid | inj_valid;
  assign div_quotient = inj_valid ? inj_q : m_q;

  typedef struct {
    logic [1:0]    who;
    logic [QW-1:0] q;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int            n_start = 0, n_valid = 0, n_err = 0;
  int            start_cyc = 0, valid_cyc = 0, err_cyc = 0;
  logic [DW-1:0] start_dvd = '0;
  exp_t          mon_e;

  always @(negedge clock) begin
    if (reset) begin
      if (div_start) begin
        n_start++;
        start_cyc = cyc;
        start_dvd = div_dividend;
      end
      if (err_timeout) begin
        n_err++;
        err_cyc = cyc;
      end
      if (valid != 3'b000) begin
        n_valid++;
        valid_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("valid_onehot", 32'(valid), 32'(3'b001 << mon_e.who));
          check("quotient", 32'(quotient), 32'(mon_e.q));
          check("grant", 32'(grant), 32'(mon_e.who));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input int dvd, input int dvs);
    case (i)
      0: begin dividend0 = DW'(dvd); divisor0 = SW'(dvs); end
      1: begin dividend1 = DW'(dvd); divisor1 = SW'(dvs); end
      default: begin dividend2 = DW'(dvd); divisor2 = SW'(dvs); end
    endcase
  endtask

  task automatic push(input int who, input int q);
    exp_t e;
    e.who = 2'(who);
    e.q   = QW'(q);
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [2:0] r);
    req = r;
    tick();
    req = 3'b000;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  int c0, s_start, s_valid, s_err, n;

  initial begin
    req = '0;
    reset = 1'b0;
    set_op(0, 0, 0); set_op(1, 0, 0); set_op(2, 0, 0);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(div_start), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_dvd", 32'(div_dividend), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b1;
    tick();

    // Simultaneous requests from rr=0, twice
    set_op(0, 5000, 50); set_op(1, 9000, 30); set_op(2, 77777, 100);
    push(0, 100); push(1, 300); push(2, 777);
    s_valid = n_valid;
    pulse(3'b111);
    drain("rr0_a", 300);
    check("rr0_a_count", 32'(n_valid - s_valid), 32'd3);

    set_op(0, 4096, 16); set_op(1, 12345, 45); set_op(2, 99999, 99);
    push(0, 256); push(1, 274); push(2, 1010);
    pulse(3'b111);
    drain("rr0_b", 300);

    // Single request latency
    set_op(0, 1000, 10);
    push(0, 100);
    c0 = cyc;
    pulse(3'b001);
    drain("single", 100);
    check("single_start_cyc", 32'(start_cyc - c0), 32'd2);
    check("single_valid_cyc", 32'(valid_cyc - c0), 32'd15);

    // Simultaneous from rr=1
    set_op(0, 800, 4); set_op(1, 600, 6); set_op(2, 1000, 3);
    push(1, 100); push(2, 333); push(0, 200);
    pulse(3'b111);
    drain("rr1", 300);

    // Divide by zero
    set_op(1, 1234, 0);
    push(1, 10'h3FF);
    s_start = n_start;
    c0 = cyc;
    pulse(3'b010);
    drain("dbz", 50);
    check("dbz_valid_cyc", 32'(valid_cyc - c0), 32'd2);
    check("dbz_no_start", 32'(n_start - s_start), 32'd0);

    // Overwrite while requester 1 in service
    set_op(1, 330, 3);
    push(1, 110); push(0, 100);
    s_valid = n_valid;
    pulse(3'b010);
    repeat (2) tick();
    set_op(0, 500, 5);
    pulse(3'b001);
    tick();
    set_op(0, 800, 8);
    pulse(3'b001);
    drain("ovw", 100);
    check("ovw_dividend", 32'(start_dvd), 32'd800);
    check("ovw_count", 32'(n_valid - s_valid), 32'd2);

    // Re-request in the grant cycle
    set_op(0, 900, 9);
    push(0, 100); push(0, 80);
    s_start = n_start;
    req = 3'b001;
    tick();
    set_op(0, 640, 8);
    req = 3'b001;
    tick();
    req = 3'b000;
    drain("regrant", 100);
    check("regrant_starts", 32'(n_start - s_start), 32'd2);

    // Timeout with another request queued behind
    model_en = 1'b0;
    set_op(2, 700, 7);
    set_op(0, 250, 5);
    push(0, 50);
    s_err = n_err;
    c0 = cyc;
    pulse(3'b100);
    repeat (3) tick();
    pulse(3'b001);
    n = 0;
    while (n_err == s_err && n < 120) begin
      tick();
      n++;
    end
    model_en = 1'b1;
    check("to_seen", 32'(n_err - s_err), 32'd1);
    check("to_cyc", 32'(err_cyc - c0), 32'd66);
    check("to_quot_held", 32'(quotient), 32'd80);
    drain("to_next", 100);
    check("to_single_pulse", 32'(n_err - s_err), 32'd1);

    // Late div_valid while idle is ignored
    s_valid = n_valid;
    inj_q = 10'h155;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (3) tick();
    check("late_quot", 32'(quotient), 32'd50);
    check("late_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("late_busy", 32'(busy), 32'd0);

    // Async reset in WAIT with another request pending
    lat = 40;
    set_op(1, 4000, 4);
    set_op(2, 3000, 3);
    pulse(3'b010);
    pulse(3'b100);
    repeat (10) tick();
    check("ar_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_dvd", 32'(div_dividend), 32'd0);
    check("ar_dvs", 32'(div_divisor), 32'd0);
    check("ar_quot", 32'(quotient), 32'd0);
    check("ar_start", 32'(div_start), 32'd0);
    check("ar_valid", 32'(valid), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    lat = 12;
    s_start = n_start;
    repeat (20) tick();
    check("ar_idle_starts", 32'(n_start - s_start), 32'd0);
    check("ar_idle_busy", 32'(busy), 32'd0);
    push(2, 1000);
    pulse(3'b100);
    drain("ar_after", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
